// File: rtl/prog_loader.sv
// Boot-time program loader: takes a length-prefixed byte stream, packs the bytes into
// little-endian 32-bit words for the instruction memory, and holds the core in reset until the image is complete.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_areset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [6:0]        state_dbg
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready; in_data may change right after.
  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_HDR0  = 7'b0000010,
    S_HDR1  = 7'b0000100,
    S_DATA  = 7'b0001000,
    S_WRITE = 7'b0010000,
    S_DONE  = 7'b0100000,
    S_ERR   = 7'b1000000
  } state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt;
  logic [15:0] n_q;
  logic [23:0] word_sr;
  logic        accept;
  logic [15:0] hdr_n;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign hdr_n     = {in_data, n_q[7:0]};
  assign last_word = (16'(words_loaded) + 16'd1) == n_q;

  // Status is decoded straight from the one-hot register so core_areset cannot glitch.
  assign in_ready    = state_q[1] | state_q[2] | state_q[3];
  assign busy        = state_q[1] | state_q[2] | state_q[3] | state_q[4];
  assign imem_we     = state_q[4];
  assign done        = state_q[5];
  assign core_areset = state_q[5];
  assign error       = state_q[6];
  assign state_dbg   = state_q;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_HDR0;
        S_HDR0:  if (accept) state_d = S_HDR1;
        S_HDR1: begin
          if (accept) begin
            if (hdr_n == 16'd0)                 state_d = S_DONE;
            else if ({1'b0, hdr_n} > CAPACITY) state_d = S_ERR;
            else                                state_d = S_DATA;
          end
        end
        S_DATA:  if (accept && byte_cnt == 2'd3) state_d = S_WRITE;
        S_WRITE: state_d = last_word ? S_DONE : S_DATA;
        S_DONE:  if (start) state_d = S_HDR0;
        S_ERR:   if (start) state_d = S_HDR0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // The 4th byte goes straight into imem_wdata; the first three wait in word_sr.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      byte_cnt     <= 2'd0;
      words_loaded <= '0;
      n_q          <= 16'd0;
      word_sr      <= 24'd0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
    end else if (!abort) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            byte_cnt     <= 2'd0;
            words_loaded <= '0;
          end
        end
        S_HDR0: if (accept) n_q[7:0] <= in_data;
        S_HDR1: begin
          if (accept) begin
            n_q[15:8] <= in_data;
            byte_cnt  <= 2'd0;
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word_sr[7:0]   <= in_data;
              2'd1: word_sr[15:8]  <= in_data;
              2'd2: word_sr[23:16] <= in_data;
              default: begin
                imem_wdata <= {in_data, word_sr};
                imem_addr  <= words_loaded[ADDR_W-1:0];
              end
            endcase
          end
        end
        S_WRITE: words_loaded <= words_loaded + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random image loads checked against a stream-level model
// of which words should land at which addresses.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        areset, start, abort, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, imem_we, core_areset, busy, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  words_loaded;
  logic [6:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  logic [7:0]  xfer_q[$];
  logic [39:0] wr_q[$];
  logic [31:0] wq[$];
  int          we_run = 0;
  int          we_max = 0;

  prog_loader #(.ADDR_W(8)) dut (
    .clk(clk), .areset(areset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_areset(core_areset), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Sampled mid-low-phase: inputs and outputs are stable until the next rising edge.
  always begin
    @(negedge clk);
    #3;
    if (in_valid && in_ready) xfer_q.push_back(in_data);
    if (imem_we) begin
      wr_q.push_back({imem_addr, imem_wdata});
      we_run++;
      if (we_run > we_max) we_max = we_run;
    end else begin
      we_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit r;
    bit sent = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 64; k++) begin
      r = in_ready;
      @(posedge clk);
      if (r) begin
        sent = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("byte_accepted", 40'(sent), 40'd1);
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[i]) send_byte(bytes[i], $urandom_range(0, max_gap));
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Model: header N, then 4*N bytes LSB first for a legal N; word i lands at address i.
  task automatic run_load(input logic [15:0] n, input logic [31:0] words[$], input int max_gap,
                          input string tag);
    logic [7:0] bytes[$];
    bit exp_err;
    int nw;
    exp_err = (n > 16'd256);
    nw      = exp_err ? 0 : int'(n);
    bytes   = {n[7:0], n[15:8]};
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < 4; k++) bytes.push_back(8'(words[i] >> (8 * k)));
    xfer_q.delete();
    wr_q.delete();
    we_max = 0;
    pulse_start();
    chk({tag, "_busy_after_start"}, 40'(busy), 40'd1);
    chk({tag, "_core_rst_after_start"}, 40'(core_areset), 40'd0);
    chk({tag, "_wl_cleared"}, 40'(words_loaded), 40'd0);
    send_stream(bytes, max_gap);
    if (nw > 0) begin
      chk({tag, "_we_last"}, 40'(imem_we), 40'd1);
      @(negedge clk);
    end
    chk({tag, "_done"}, 40'(done), 40'(!exp_err));
    chk({tag, "_error"}, 40'(error), 40'(exp_err));
    chk({tag, "_core_areset"}, 40'(core_areset), 40'(!exp_err));
    chk({tag, "_busy_end"}, 40'(busy), 40'd0);
    chk({tag, "_in_ready_end"}, 40'(in_ready), 40'd0);
    chk({tag, "_words_loaded"}, 40'(words_loaded), 40'(nw));
    chk({tag, "_xfer_count"}, 40'(xfer_q.size()), 40'(bytes.size()));
    for (int i = 0; i < bytes.size() && i < xfer_q.size(); i++)
      chk({tag, "_xfer_byte"}, 40'(xfer_q[i]), 40'(bytes[i]));
    chk({tag, "_write_count"}, 40'(wr_q.size()), 40'(nw));
    for (int i = 0; i < nw && i < wr_q.size(); i++)
      chk({tag, "_write"}, wr_q[i], {8'(i), words[i]});
    if (nw > 0) begin
      chk({tag, "_we_width"}, 40'(we_max), 40'd1);
      chk({tag, "_addr_hold"}, 40'(imem_addr), 40'(nw - 1));
      chk({tag, "_wdata_hold"}, 40'(imem_wdata), 40'(words[nw-1]));
    end
  endtask

  initial begin
    areset   = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    chk("rst_in_ready", 40'(in_ready), 40'd0);
    chk("rst_imem_we", 40'(imem_we), 40'd0);
    chk("rst_core_areset", 40'(core_areset), 40'd0);
    chk("rst_status", 40'({busy, done, error}), 40'd0);
    chk("rst_words_loaded", 40'(words_loaded), 40'd0);
    chk("rst_addr_data", 40'({imem_addr, imem_wdata}), 40'd0);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);

    // Directed image of two words.
    wq = {32'h00500513, 32'h00A00593};
    run_load(16'd2, wq, 2, "t1");

    // Empty image.
    wq.delete();
    run_load(16'd0, wq, 1, "t2");

    // Reload from DONE with a single word.
    wq = {32'hDEADBEEF};
    run_load(16'd1, wq, 0, "t6");

    // Oversized header goes to ERR; a new start clears it.
    run_load(16'd257, wq, 1, "t3");
    pulse_start();
    chk("t3_restart_error", 40'(error), 40'd0);
    chk("t3_restart_busy", 40'(busy), 40'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t3_abort_busy", 40'(busy), 40'd0);

    // Random images with irregular spacing and valid held through WRITE.
    for (int r = 0; r < 5; r++) begin
      wq.delete();
      for (int i = 0, int n = $urandom_range(1, 9); i < n; i++) wq.push_back($urandom);
      run_load(16'(wq.size()), wq, (r == 0) ? 0 : 3, "rand");
    end

    // Abort mid-word, then a load must still work.
    pulse_start();
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 40'(busy), 40'd0);
    chk("abort_in_ready", 40'(in_ready), 40'd0);
    chk("abort_done", 40'(done), 40'd0);
    wq = {32'h12345678, 32'h9ABCDEF0};
    run_load(16'd2, wq, 1, "after_abort");

    // Abort and start together in DONE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", 40'(busy), 40'd0);
    chk("abort_start_done", 40'(done), 40'd0);
    chk("abort_start_core", 40'(core_areset), 40'd0);

    // Asynchronous reset after 6 of the 10 bytes of the directed image.
    pulse_start();
    send_stream('{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00}, 1);
    #2;
    areset = 1'b0;
    #1;
    chk("mid_rst_in_ready", 40'(in_ready), 40'd0);
    chk("mid_rst_imem_we", 40'(imem_we), 40'd0);
    chk("mid_rst_status", 40'({busy, done, error, core_areset}), 40'd0);
    chk("mid_rst_words_loaded", 40'(words_loaded), 40'd0);
    chk("mid_rst_addr_data", 40'({imem_addr, imem_wdata}), 40'd0);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    wq = {32'h00500513, 32'h00A00593};
    run_load(16'd2, wq, 2, "t5");

    // Full capacity image: N equal to the memory size is legal.
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back($urandom);
    run_load(16'd256, wq, 0, "full");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
